// File: rtl/music_pkg.sv
// Shared definitions for the music voice path: song-word field layout,
// command opcodes, note field widths and the sequencer state encoding.
package music_pkg;

  // Note field widths, shared with note_player.
  localparam int PITCH_W = 6;
  localparam int DUR_W   = 5;
  localparam int INST_W  = 4;

  // Song word layout.
  localparam int WORD_W    = 16;
  localparam int TYPE_BIT  = 15;  // 0 = note, 1 = command
  localparam int OPC_LSB   = 13;
  localparam int OPC_W     = 2;
  localparam int PITCH_LSB = 9;
  localparam int DUR_LSB   = 4;
  localparam int INST_LSB  = 0;

  // Command opcodes; the remaining encodings behave as NOP.
  localparam logic [OPC_W-1:0] OP_END  = 2'b00;
  localparam logic [OPC_W-1:0] OP_JUMP = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_LOAD   = 3'd3,
    ST_WAIT   = 3'd4
  } seq_state_e;

endpackage

// File: rtl/song_word_decode.sv
// Combinational split of a 16-bit song word into note fields and
// command fields. Both views are always produced; the caller picks one
// based on is_note.
module song_word_decode
  import music_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic [WORD_W-1:0]  word,
  output logic               is_note,
  output logic [OPC_W-1:0]   opcode,
  output logic [PITCH_W-1:0] pitch,
  output logic [DUR_W-1:0]   duration,
  output logic [INST_W-1:0]  instrument,
  output logic [ADDR_W-1:0]  target
);

  assign is_note    = ~word[TYPE_BIT];
  assign opcode     = word[OPC_LSB +: OPC_W];
  assign pitch      = word[PITCH_LSB +: PITCH_W];
  assign duration   = word[DUR_LSB +: DUR_W];
  assign instrument = word[INST_LSB +: INST_W];
  assign target     = word[ADDR_W-1:0];

endmodule

// File: rtl/track_sequencer.sv
// Per-voice song sequencer: walks the song ROM, turns notes into a
// one-cycle load towards note_player and follows END/JUMP commands.
// All outputs come straight from registers.
module track_sequencer
  import music_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int MAX_JUMPS = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic               i_stop,
  input  logic [ADDR_W-1:0]  i_start_addr,
  output logic [ADDR_W-1:0]  o_rom_addr,
  input  logic [WORD_W-1:0]  i_rom_data,
  output logic               o_load,
  output logic [PITCH_W-1:0] o_pitch,
  output logic [DUR_W-1:0]   o_duration,
  output logic [INST_W-1:0]  o_instrument,
  input  logic               i_done,
  output logic               o_playing,
  output logic               o_error
);

  // Wide enough to hold MAX_JUMPS-1 for any MAX_JUMPS >= 1.
  localparam int JCNT_W = $clog2(MAX_JUMPS + 1);
  localparam logic [JCNT_W-1:0] JCNT_LAST = JCNT_W'(MAX_JUMPS - 1);

  seq_state_e           state_r, state_nx;
  logic [ADDR_W-1:0]    addr_r, addr_nx;
  logic                 load_r, load_nx;
  logic [PITCH_W-1:0]   pitch_r, pitch_nx;
  logic [DUR_W-1:0]     dur_r, dur_nx;
  logic [INST_W-1:0]    inst_r, inst_nx;
  logic                 playing_r, playing_nx;
  logic                 error_r, error_nx;
  logic [JCNT_W-1:0]    jcnt_r, jcnt_nx;

  logic                 dec_is_note_s;
  logic [OPC_W-1:0]     dec_opcode_s;
  logic [PITCH_W-1:0]   dec_pitch_s;
  logic [DUR_W-1:0]     dec_dur_s;
  logic [INST_W-1:0]    dec_inst_s;
  logic [ADDR_W-1:0]    dec_target_s;

  song_word_decode #(
    .ADDR_W (ADDR_W)
  ) u_decode (
    .word       (i_rom_data),
    .is_note    (dec_is_note_s),
    .opcode     (dec_opcode_s),
    .pitch      (dec_pitch_s),
    .duration   (dec_dur_s),
    .instrument (dec_inst_s),
    .target     (dec_target_s)
  );

  // Next-state and next-output logic; stop overrides every state.
  always_comb begin
    state_nx = state_r;
    addr_nx  = addr_r;
    load_nx  = 1'b0;
    pitch_nx = pitch_r;
    dur_nx   = dur_r;
    inst_nx  = inst_r;
    error_nx = error_r;
    jcnt_nx  = jcnt_r;

    if (i_stop) begin
      state_nx = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (i_start) begin
            addr_nx  = i_start_addr;
            error_nx = 1'b0;
            jcnt_nx  = '0;
            state_nx = ST_FETCH;
          end else begin
            state_nx = ST_IDLE;
          end
        end
        // ROM address was presented on entry; wait out the read latency.
        ST_FETCH: begin
          state_nx = ST_DECODE;
        end
        ST_DECODE: begin
          if (dec_is_note_s) begin
            pitch_nx = dec_pitch_s;
            dur_nx   = dec_dur_s;
            inst_nx  = dec_inst_s;
            load_nx  = 1'b1;
            addr_nx  = addr_r + ADDR_W'(1);
            jcnt_nx  = '0;
            state_nx = ST_LOAD;
          end else begin
            case (dec_opcode_s)
              OP_END: begin
                state_nx = ST_IDLE;
              end
              OP_JUMP: begin
                if (jcnt_r == JCNT_LAST) begin
                  error_nx = 1'b1;
                  state_nx = ST_IDLE;
                end else begin
                  jcnt_nx  = jcnt_r + JCNT_W'(1);
                  addr_nx  = dec_target_s;
                  state_nx = ST_FETCH;
                end
              end
              default: begin
                addr_nx  = addr_r + ADDR_W'(1);
                state_nx = ST_FETCH;
              end
            endcase
          end
        end
        ST_LOAD: begin
          state_nx = ST_WAIT;
        end
        ST_WAIT: begin
          if (i_done) begin
            state_nx = ST_FETCH;
          end else begin
            state_nx = ST_WAIT;
          end
        end
        default: begin
          state_nx = ST_IDLE;
        end
      endcase
    end

    playing_nx = (state_nx != ST_IDLE);
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r   <= ST_IDLE;
      addr_r    <= '0;
      load_r    <= 1'b0;
      pitch_r   <= '0;
      dur_r     <= '0;
      inst_r    <= '0;
      playing_r <= 1'b0;
      error_r   <= 1'b0;
      jcnt_r    <= '0;
    end else begin
      state_r   <= state_nx;
      addr_r    <= addr_nx;
      load_r    <= load_nx;
      pitch_r   <= pitch_nx;
      dur_r     <= dur_nx;
      inst_r    <= inst_nx;
      playing_r <= playing_nx;
      error_r   <= error_nx;
      jcnt_r    <= jcnt_nx;
    end
  end

  assign o_rom_addr   = addr_r;
  assign o_load       = load_r;
  assign o_pitch      = pitch_r;
  assign o_duration   = dur_r;
  assign o_instrument = inst_r;
  assign o_playing    = playing_r;
  assign o_error      = error_r;

endmodule

// File: tb/tb_track_sequencer.sv
// Directed bench for track_sequencer with a behavioural synchronous ROM.
module tb_track_sequencer;

  localparam int ADDR_W = 8;
  localparam logic [15:0] END_W = 16'h8000;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              stop;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W-1:0] rom_addr;
  logic [15:0]       rom_data;
  logic              load;
  logic [5:0]        pitch;
  logic [4:0]        duration;
  logic [3:0]        instrument;
  logic              done;
  logic              playing;
  logic              error;

  logic [15:0] rom [0:255];
  int chk_cnt;
  int pass_cnt;

  track_sequencer #(
    .ADDR_W    (ADDR_W),
    .MAX_JUMPS (4)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .i_stop       (stop),
    .i_start_addr (start_addr),
    .o_rom_addr   (rom_addr),
    .i_rom_data   (rom_data),
    .o_load       (load),
    .o_pitch      (pitch),
    .o_duration   (duration),
    .o_instrument (instrument),
    .i_done       (done),
    .o_playing    (playing),
    .o_error      (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Song ROM with one cycle of read latency.
  always @(posedge clk) rom_data <= rom[rom_addr];

  function automatic logic [15:0] note_w(input logic [5:0] p, input logic [4:0] d,
                                         input logic [3:0] i);
    return {1'b0, p, d, i};
  endfunction

  function automatic logic [15:0] jump_w(input logic [7:0] t);
    return {3'b101, 5'b00000, t};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; done = 1'b0; start_addr = 8'h00;
    for (int k = 0; k < 256; k++) rom[k] = 16'h0000;
    #1;
    chk_cnt++;
    if ({rom_addr, load, pitch, duration, instrument, playing, error} !== 25'd0)
      $display("FAIL reset_outputs got=%h exp=0",
               {rom_addr, load, pitch, duration, instrument, playing, error});
    else pass_cnt++;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk_cnt++;
    if (playing !== 1'b0 || load !== 1'b0)
      $display("FAIL reset_idle playing=%b load=%b exp 0/0", playing, load);
    else pass_cnt++;
  endtask

  task automatic test_single_note();
    rom[8'h10] = note_w(6'd12, 5'd3, 4'd2);
    rom[8'h11] = END_W;
    start_addr = 8'h10; start = 1'b1;
    tick(); start = 1'b0;
    chk_cnt++;
    if (load !== 1'b0 || playing !== 1'b1 || rom_addr !== 8'h10)
      $display("FAIL single_c1 load=%b playing=%b addr=%h exp 0/1/10", load, playing, rom_addr);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (load !== 1'b0) $display("FAIL single_c2_load got=%b exp=0", load);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (load !== 1'b1) $display("FAIL single_c3_load got=%b exp=1", load);
    else pass_cnt++;
    chk_cnt++;
    if (pitch !== 6'd12 || duration !== 5'd3 || instrument !== 4'd2)
      $display("FAIL single_fields got=%0d/%0d/%0d exp=12/3/2", pitch, duration, instrument);
    else pass_cnt++;
    chk_cnt++;
    if (rom_addr !== 8'h11) $display("FAIL single_addr got=%h exp=11", rom_addr);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (load !== 1'b0 || playing !== 1'b1)
      $display("FAIL single_c4 load=%b playing=%b exp 0/1", load, playing);
    else pass_cnt++;
    stop = 1'b1; tick(); stop = 1'b0;
    chk_cnt++;
    if (playing !== 1'b0) $display("FAIL single_stop playing=%b exp=0", playing);
    else pass_cnt++;
  endtask

  task automatic test_two_notes();
    int loads;
    rom[8'h30] = note_w(6'd20, 5'd7, 4'd5);
    rom[8'h31] = note_w(6'd33, 5'd17, 4'd9);
    rom[8'h32] = END_W;
    start_addr = 8'h30; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick();
    chk_cnt++;
    if (load !== 1'b1 || pitch !== 6'd20 || duration !== 5'd7 || instrument !== 4'd5)
      $display("FAIL two_first load=%b fields=%0d/%0d/%0d exp 1 20/7/5",
               load, pitch, duration, instrument);
    else pass_cnt++;
    for (int k = 0; k < 5; k++) tick();
    done = 1'b1; tick(); done = 1'b0;
    chk_cnt++;
    if (load !== 1'b0) $display("FAIL two_done_c1 load=%b exp=0", load);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (load !== 1'b0) $display("FAIL two_done_c2 load=%b exp=0", load);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (load !== 1'b1 || pitch !== 6'd33 || duration !== 5'd17 || instrument !== 4'd9)
      $display("FAIL two_second load=%b fields=%0d/%0d/%0d exp 1 33/17/9",
               load, pitch, duration, instrument);
    else pass_cnt++;
    chk_cnt++;
    if (rom_addr !== 8'h32) $display("FAIL two_addr got=%h exp=32", rom_addr);
    else pass_cnt++;
    for (int k = 0; k < 5; k++) tick();
    done = 1'b1; tick(); done = 1'b0;
    tick(); tick();
    chk_cnt++;
    if (playing !== 1'b0 || pitch !== 6'd33)
      $display("FAIL two_end playing=%b pitch=%0d exp 0/33", playing, pitch);
    else pass_cnt++;
    loads = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (load === 1'b1) loads++;
    end
    chk_cnt++;
    if (loads != 0 || playing !== 1'b0)
      $display("FAIL two_after_end loads=%0d playing=%b exp 0/0", loads, playing);
    else pass_cnt++;
  endtask

  task automatic test_jump();
    int loads;
    rom[8'h20] = jump_w(8'h05);
    rom[8'h05] = note_w(6'd7, 5'd9, 4'd1);
    rom[8'h06] = jump_w(8'h50);
    rom[8'h50] = jump_w(8'h51);
    rom[8'h51] = jump_w(8'h52);
    rom[8'h52] = note_w(6'd40, 5'd2, 4'd3);
    start_addr = 8'h20; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick();
    chk_cnt++;
    if (rom_addr !== 8'h05 || load !== 1'b0)
      $display("FAIL jump_target addr=%h load=%b exp 05/0", rom_addr, load);
    else pass_cnt++;
    tick(); tick();
    chk_cnt++;
    if (load !== 1'b1 || pitch !== 6'd7 || duration !== 5'd9 || instrument !== 4'd1)
      $display("FAIL jump_note load=%b fields=%0d/%0d/%0d exp 1 7/9/1",
               load, pitch, duration, instrument);
    else pass_cnt++;
    tick();
    done = 1'b1; tick(); done = 1'b0;
    loads = 0;
    for (int k = 0; k < 7; k++) begin
      tick();
      if (load === 1'b1) loads++;
    end
    chk_cnt++;
    if (loads != 0) $display("FAIL jump_chain_early loads=%0d exp=0", loads);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (load !== 1'b1 || pitch !== 6'd40 || error !== 1'b0)
      $display("FAIL jump_cnt_reset load=%b pitch=%0d err=%b exp 1/40/0", load, pitch, error);
    else pass_cnt++;
    stop = 1'b1; tick(); stop = 1'b0;
  endtask

  task automatic test_jump_loop();
    rom[8'h00] = jump_w(8'h00);
    start_addr = 8'h00; start = 1'b1;
    tick(); start = 1'b0;
    for (int k = 0; k < 7; k++) tick();
    chk_cnt++;
    if (playing !== 1'b1 || error !== 1'b0)
      $display("FAIL loop_4th_decode playing=%b err=%b exp 1/0", playing, error);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (playing !== 1'b0 || error !== 1'b1)
      $display("FAIL loop_error playing=%b err=%b exp 0/1", playing, error);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (error !== 1'b1) $display("FAIL loop_sticky err=%b exp=1", error);
    else pass_cnt++;
    start_addr = 8'h10; start = 1'b1;
    tick(); start = 1'b0;
    chk_cnt++;
    if (error !== 1'b0 || playing !== 1'b1)
      $display("FAIL loop_restart err=%b playing=%b exp 0/1", error, playing);
    else pass_cnt++;
    stop = 1'b1; tick(); stop = 1'b0;
  endtask

  task automatic test_stop();
    int loads;
    start_addr = 8'h10; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick(); tick();
    stop = 1'b1; tick(); stop = 1'b0;
    chk_cnt++;
    if (playing !== 1'b0 || load !== 1'b0 || pitch !== 6'd12)
      $display("FAIL stop_wait playing=%b load=%b pitch=%0d exp 0/0/12", playing, load, pitch);
    else pass_cnt++;
    start = 1'b1; stop = 1'b1;
    tick(); start = 1'b0; stop = 1'b0;
    chk_cnt++;
    if (playing !== 1'b0) $display("FAIL stop_wins playing=%b exp=0", playing);
    else pass_cnt++;
    loads = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (load === 1'b1 || playing === 1'b1) loads++;
    end
    chk_cnt++;
    if (loads != 0) $display("FAIL stop_quiet activity=%0d exp=0", loads);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_fetch();
    rom[8'hFF] = note_w(6'd63, 5'd31, 4'd15);
    start_addr = 8'h10; start = 1'b1;
    tick(); start = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk_cnt++;
    if ({rom_addr, load, pitch, duration, instrument, playing, error} !== 25'd0)
      $display("FAIL reset_async got=%h exp=0",
               {rom_addr, load, pitch, duration, instrument, playing, error});
    else pass_cnt++;
    tick();
    rst_n = 1'b1;
    tick();
    chk_cnt++;
    if (load !== 1'b0 || playing !== 1'b0)
      $display("FAIL reset_no_partial load=%b playing=%b exp 0/0", load, playing);
    else pass_cnt++;
    start_addr = 8'hFF; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick();
    chk_cnt++;
    if (load !== 1'b1 || pitch !== 6'd63 || duration !== 5'd31 || instrument !== 4'd15)
      $display("FAIL wrap_note load=%b fields=%0d/%0d/%0d exp 1 63/31/15",
               load, pitch, duration, instrument);
    else pass_cnt++;
    chk_cnt++;
    if (rom_addr !== 8'h00 || error !== 1'b0)
      $display("FAIL wrap_addr addr=%h err=%b exp 00/0", rom_addr, error);
    else pass_cnt++;
    stop = 1'b1; tick(); stop = 1'b0;
  endtask

  initial begin
    chk_cnt = 0;
    pass_cnt = 0;
    test_reset();
    test_single_note();
    test_two_notes();
    test_jump();
    test_jump_loop();
    test_stop();
    test_reset_mid_fetch();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/track_sequencer.md
Name: track_sequencer

Overview:
- Upstream feeder for note_player.
- Walks a song table in a synchronous 16-bit ROM (1-cycle read latency) and decodes each word into a note or a control command.
- Presents pitch/duration/instrument with a one-cycle load pulse, then waits for note_player's done before fetching the next event.
- One instance per voice; start/stop is driven by the top-level control.

Parameters:
- ADDR_W, 8, song ROM address width.
- MAX_JUMPS, 4, consecutive JUMP commands allowed without an intervening note before an error is flagged.

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_start  in  1  start pulse; honoured only in IDLE
- i_stop  in  1  stop pulse; honoured in any state
- i_start_addr  in  ADDR_W  first song-table address
- o_rom_addr  out  ADDR_W  song ROM address
- i_rom_data  in  16  song ROM data, valid one cycle after o_rom_addr
- o_load  out  1  one-cycle load pulse to note_player
- o_pitch  out  6  note pitch (0 = rest, passed through)
- o_duration  out  5  note duration in ticks
- o_instrument  out  4  instrument index
- i_done  in  1  note_player done, level
- o_playing  out  1  high in any state other than IDLE
- o_error  out  1  sticky jump-loop error; cleared by the next accepted start

Behaviour:
- Reset (async, i_rst_n low): state IDLE; all outputs 0; jump counter 0.
- Word format:
  - bit15=0: NOTE. [14:9] pitch, [8:4] duration, [3:0] instrument.
  - bit15=1: COMMAND, opcode [14:13]:
    - 00 END: go to IDLE.
    - 01 JUMP: target [ADDR_W-1:0].
    - 10, 11: reserved, treated as NOP (advance address).
- States:
  - IDLE: on i_start (and no i_stop) set o_rom_addr=i_start_addr, clear o_error and the jump counter, go to FETCH.
  - FETCH: one wait cycle for ROM latency, then go to DECODE.
  - DECODE: sample i_rom_data.
    - NOTE: register pitch/duration/instrument, assert o_load next cycle, o_rom_addr+1, clear the jump counter, go to LOAD.
    - JUMP: if jump counter = MAX_JUMPS-1, set o_error and go to IDLE. Otherwise increment the counter, set o_rom_addr=target, go to FETCH.
    - END: go to IDLE.
    - NOP: o_rom_addr+1, go to FETCH.
  - LOAD: o_load=1 for exactly this cycle, then go to WAIT.
  - WAIT: when i_done=1 go to FETCH. i_done is sampled only in WAIT; note_player drops done the cycle after it samples load.
- Latency: i_start edge to o_load high = 3 cycles (FETCH, DECODE, LOAD). i_done sampled high to next o_load = 3 cycles.
- o_pitch/o_duration/o_instrument are held stable from LOAD until the next DECODE of a note.
- Address wrap: o_rom_addr increments modulo 2^ADDR_W with no error.
- i_stop in any state: go to IDLE next cycle, o_load forced 0, note fields held. If i_start and i_stop arrive in the same cycle, stop wins.
- i_start outside IDLE: ignored.
- Reset mid-operation: immediate return to reset values; no partial load pulse.

Decomposition:
- Shared package music_pkg:
  - song word field offsets/widths.
  - opcode constants OP_END, OP_JUMP.
  - state enum for track_sequencer.
  - PITCH_W=6, DUR_W=5, INST_W=4 (shared with note_player).
- Sub-module song_word_decode: combinational; splits the ROM word into is_note, opcode, pitch, duration, instrument, target. Keeps the FSM readable and is reusable by a future multi-voice sequencer.

Test Plan:
- Reset, then start at 0x10 with ROM[0x10]=NOTE(pitch 12, dur 3, inst 2) -> o_load high exactly 3 cycles after start for one cycle; o_pitch=12, o_duration=3, o_instrument=2; o_rom_addr=0x11.
- Two-note song followed by END, i_done asserted 5 cycles after each load -> second o_load 3 cycles after i_done; after END, o_playing=0 and no further loads.
- ROM[0x20]=JUMP 0x05, ROM[0x05]=NOTE -> o_load carries the 0x05 note 5 cycles after start; jump counter resets after the note.
- ROM[0]=JUMP 0, MAX_JUMPS=4 -> o_error=1, o_playing=0 after the 4th decode; next i_start clears o_error.
- i_stop asserted during WAIT, and separately i_start+i_stop in the same cycle from IDLE -> IDLE next cycle, o_load never pulses.
- i_rst_n pulsed low mid-FETCH -> all outputs 0 asynchronously; normal start afterwards; start at 0xFF with a NOTE there -> o_rom_addr wraps to 0x00.
